sha256_block_padder: RTL

//  Upstream feeder for the SHA-256 hash core. Reads an NUM_OF_WORDS-word message from testbench SRAM.

---
 rtl/sha256_pkg.sv | 42 ++++
 rtl/sha256_block_padder.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared types and padding helpers for the SHA-256 front end
package sha256_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        PRESENT,
        DONE
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [3:0] slot;
        logic       from_mem;
    } fill_pipe_t;

    localparam logic [31:0] SHA256_PAD_WORD = 32'h8000_0000;

    // Marker plus 64-bit length need three extra words beyond the message.
    function automatic int num_blocks(input int words);
        return (words + 3 + 15) / 16;
    endfunction

    function automatic logic [31:0] pad_word(
        input logic [15:0] g,
        input logic [3:0]  slot,
        input logic        last,
        input logic [31:0] mem_word,
        input int          words
    );
        if (int'(g) < words) begin
            return mem_word;
        end else if (int'(g) == words) begin
            return SHA256_PAD_WORD;
        end else if (last && slot == 4'd15) begin
            return 32'(words * 32);
        end else begin
            return 32'h0;
        end
    endfunction

endpackage

// File: rtl/sha256_block_padder.sv
// rtl/sha256_block_padder.sv - reads a message from SRAM and presents padded 512-bit blocks
module sha256_block_padder
    import sha256_pkg::*;
#(
    parameter int NUM_OF_WORDS = 20
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [15:0]  message_addr,
    output logic         mem_clk,
    output logic         mem_we,
    output logic [15:0]  mem_addr,
    input  logic [31:0]  mem_read_data,
    output logic         block_valid,
    input  logic         block_ready,
    output logic [511:0] block_data,
    output logic [7:0]   block_idx,
    output logic         block_last,
    output logic         busy,
    output logic         done
);

    localparam int          NUM_BLOCKS = num_blocks(NUM_OF_WORDS);
    localparam logic [7:0]  LAST_BLK   = 8'(NUM_BLOCKS - 1);
    localparam logic [15:0] NWORDS     = 16'(NUM_OF_WORDS);

    state_e      state_q, state_d;
    logic [4:0]  slot_q, slot_d;
    logic [7:0]  blk_q, blk_d;
    logic [15:0] base_q, base_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    fill_pipe_t  pipe_q, pipe_d;
    logic [31:0] buf_q [16];
    logic [31:0] buf_d [16];
    logic        block_valid_q, block_valid_d;
    logic        block_last_q, block_last_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;

    logic [15:0] issue_g, next_g, land_g, first_g;

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        blk_d         = blk_q;
        base_d        = base_q;
        mem_addr_d    = mem_addr_q;
        pipe_d        = '0;
        buf_d         = buf_q;
        block_valid_d = block_valid_q;
        block_last_d  = block_last_q;
        done_d        = 1'b0;

        issue_g = {4'b0, blk_q, slot_q[3:0]};
        next_g  = issue_g + 16'd1;
        land_g  = {4'b0, blk_q, pipe_q.slot};
        first_g = {4'b0, blk_q + 8'd1, 4'b0};

        // Landing stage: every slot, constant or fetched, is written one cycle after issue.
        if (pipe_q.valid) begin
            buf_d[pipe_q.slot] = pad_word(land_g, pipe_q.slot, blk_q == LAST_BLK,
                                          pipe_q.from_mem ? mem_read_data : 32'h0,
                                          NUM_OF_WORDS);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d     = message_addr;
                    blk_d      = 8'd0;
                    slot_d     = 5'd0;
                    mem_addr_d = message_addr;
                    state_d    = FILL;
                end
            end
            FILL: begin
                if (!slot_q[4]) begin
                    pipe_d.valid    = 1'b1;
                    pipe_d.slot     = slot_q[3:0];
                    pipe_d.from_mem = issue_g < NWORDS;
                    slot_d          = slot_q + 5'd1;
                    // Address for the following issue cycle; held once the message is exhausted.
                    if (slot_q[3:0] != 4'd15 && next_g < NWORDS) begin
                        mem_addr_d = base_q + next_g;
                    end
                end
                if (pipe_q.valid && pipe_q.slot == 4'd15) begin
                    state_d       = PRESENT;
                    block_valid_d = 1'b1;
                    block_last_d  = blk_q == LAST_BLK;
                end
            end
            PRESENT: begin
                if (block_ready) begin
                    block_valid_d = 1'b0;
                    block_last_d  = 1'b0;
                    if (blk_q != LAST_BLK) begin
                        blk_d   = blk_q + 8'd1;
                        slot_d  = 5'd0;
                        state_d = FILL;
                        if (first_g < NWORDS) begin
                            mem_addr_d = base_q + first_g;
                        end
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            slot_q        <= '0;
            blk_q         <= '0;
            base_q        <= '0;
            mem_addr_q    <= '0;
            pipe_q        <= '0;
            block_valid_q <= 1'b0;
            block_last_q  <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            blk_q         <= blk_d;
            base_q        <= base_d;
            mem_addr_q    <= mem_addr_d;
            pipe_q        <= pipe_d;
            block_valid_q <= block_valid_d;
            block_last_q  <= block_last_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            buf_q         <= buf_d;
        end
    end

    for (genvar i = 0; i < 16; i++) begin : g_flat
        assign block_data[511 - 32*i -: 32] = buf_q[i];
    end

    assign mem_clk     = clk;
    assign mem_we      = 1'b0;
    assign mem_addr    = mem_addr_q;
    assign block_valid = block_valid_q;
    assign block_idx   = blk_q;
    assign block_last  = block_last_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
